// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding / load-use hazard unit.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package fwd_pkg;

  // Container widths of a tracked entry; the top level zero-extends into them.
  localparam int FWD_RD_W  = 5;
  localparam int FWD_LAT_W = 4;

  localparam int FWD_SEL_RF = 0;
  localparam int LAT_ALU    = 1;
  localparam int LAT_LOAD   = 2;

  typedef struct packed {
    logic                 valid;
    logic [FWD_RD_W-1:0]  rd;
    logic [FWD_LAT_W-1:0] lat;
  } fwd_entry_t;

  // Clamp a requested result latency into [1, num_fwd].
  function automatic logic [FWD_LAT_W-1:0] fwd_clamp_lat(input int lat, input int num_fwd);
    int l;
    l = lat;
    if (l < 1) l = 1;
    if (l > num_fwd) l = num_fwd;
    return FWD_LAT_W'(l);
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Youngest-producer search for one source operand across all tracked stages.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; rdy_o low tells the top level the youngest match is not yet on a bus.
module fwd_match
  import fwd_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int NUM_FWD = 2,
  parameter int SEL_W   = $clog2(NUM_FWD + 1)
) (
  input  logic [REG_AW-1:0]              rs_i,
  input  fwd_entry_t [NUM_FWD-1:0]       ent_i,
  output logic [SEL_W-1:0]               sel_o,
  output logic                           rdy_o
);

  logic [FWD_RD_W-1:0] rs_ext;

  // Scan oldest to youngest so the smallest matching stage is the one left standing.
  always_comb begin
    rs_ext = '0;
    rs_ext[REG_AW-1:0] = rs_i;
    sel_o = '0;
    rdy_o = 1'b1;
    for (int k = NUM_FWD; k >= 1; k--) begin
      if (ent_i[k-1].valid && (ent_i[k-1].rd == rs_ext) && (rs_ext != '0)) begin
        sel_o = SEL_W'(k);
        rdy_o = (int'(ent_i[k-1].lat) <= k);
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding select and load-use stall generation over NUM_FWD tracked post-EX stages.
// Latency: fwd_sel/stall combinational (0 cycles); entry shift register updates on each clk edge.
// Backpressure: stall holds PC, IF/ID and ID/EX and injects a bubble; flush clears all stages.
// Optional feature macro: FWD_HAZARD_PERF_EN adds a saturating 32-bit stall counter output.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2,
  parameter int NUM_FWD = 2,
  parameter int SEL_W   = $clog2(NUM_FWD + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ex_valid,
  input  logic                      ex_reg_write,
  input  logic [REG_AW-1:0]         ex_rd,
  input  logic [SEL_W-1:0]          ex_lat,
  input  logic [NUM_SRC*REG_AW-1:0] ex_rs,
  input  logic                      flush,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
  output logic                      stall
`ifdef FWD_HAZARD_PERF_EN
  ,
  output logic [31:0]               stall_cnt
`endif
);

  fwd_entry_t [NUM_FWD-1:0] ent_q;
  fwd_entry_t [NUM_FWD-1:0] ent_d;
  fwd_entry_t               new_ent;
  logic [NUM_SRC-1:0]       src_rdy;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      fwd_match #(
        .REG_AW  (REG_AW),
        .NUM_FWD (NUM_FWD),
        .SEL_W   (SEL_W)
      ) u_match (
        .rs_i  (ex_rs[gi*REG_AW +: REG_AW]),
        .ent_i (ent_q),
        .sel_o (fwd_sel[gi*SEL_W +: SEL_W]),
        .rdy_o (src_rdy[gi])
      );
    end
  endgenerate

  // A real instruction stalls while any operand's youngest producer is not yet ready.
  always_comb begin
    stall = ex_valid && !(&src_rdy);
  end

  // Build the ID/EX entry and the shifted stage vector; flush wipes everything, stall injects a bubble.
  always_comb begin
    new_ent = '0;
    new_ent.rd[REG_AW-1:0] = ex_rd;
    new_ent.lat   = fwd_clamp_lat(int'(ex_lat), NUM_FWD);
    new_ent.valid = ex_valid && ex_reg_write && (ex_rd != '0);
    ent_d = ent_q;
    ent_d[0] = (flush || stall) ? fwd_entry_t'('0) : new_ent;
    for (int k = 1; k < NUM_FWD; k++) begin
      ent_d[k] = flush ? fwd_entry_t'('0) : ent_q[k-1];
    end
  end

  // Stage shift register; the last stage simply falls off into the register file.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ent_q <= '0;
    end else begin
      ent_q <= ent_d;
    end
  end

`ifdef FWD_HAZARD_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;

  // Count non-flushed stall cycles, holding at the top value.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && !flush && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed-vector bench for fwd_hazard_unit with a queue-based scoreboard.
// The driver pushes hand-computed expectations; a negedge monitor pops and compares.
module tb_fwd_hazard_unit;

  localparam int REG_AW  = 5;
  localparam int NUM_SRC = 2;
  localparam int NUM_FWD = 4;
  localparam int SEL_W   = $clog2(NUM_FWD + 1);

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      ex_valid;
  logic                      ex_reg_write;
  logic [REG_AW-1:0]         ex_rd;
  logic [SEL_W-1:0]          ex_lat;
  logic [NUM_SRC*REG_AW-1:0] ex_rs;
  logic                      flush;
  logic [NUM_SRC*SEL_W-1:0]  fwd_sel;
  logic                      stall;
`ifdef FWD_HAZARD_PERF_EN
  logic [31:0]               stall_cnt;
`endif

  fwd_hazard_unit #(
    .REG_AW  (REG_AW),
    .NUM_SRC (NUM_SRC),
    .NUM_FWD (NUM_FWD),
    .SEL_W   (SEL_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_valid     (ex_valid),
    .ex_reg_write (ex_reg_write),
    .ex_rd        (ex_rd),
    .ex_lat       (ex_lat),
    .ex_rs        (ex_rs),
    .flush        (flush),
    .fwd_sel      (fwd_sel),
    .stall        (stall)
`ifdef FWD_HAZARD_PERF_EN
    ,
    .stall_cnt    (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int sel0;
    int sel1;
    int stl;
    int cnt;
    int id;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   cnt_model = 0;
  int   vec_id = 0;
  bit   done = 1'b0;

  task automatic chk(input string name, input int id, input int act, input int want);
    n_total++;
    if (act == want) n_pass++;
    else $display("FAIL %s vec %0d: got %0d, expected %0d", name, id, act, want);
  endtask

  // Monitor: compare the combinational outputs mid-cycle against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("fwd_sel0", e.id, int'(fwd_sel[0 +: SEL_W]), e.sel0);
      chk("fwd_sel1", e.id, int'(fwd_sel[SEL_W +: SEL_W]), e.sel1);
      chk("stall", e.id, int'(stall), e.stl);
`ifdef FWD_HAZARD_PERF_EN
      chk("stall_cnt", e.id, int'(stall_cnt), e.cnt);
`endif
    end
  end

  // One cycle: drive inputs, push expectation, advance to just after the next edge.
  task automatic step(input bit v, input bit rw, input int rd, input int lat,
                      input int rs0, input int rs1, input bit fl,
                      input int s0, input int s1, input int st);
    exp_t e;
    ex_valid     = v;
    ex_reg_write = rw;
    ex_rd        = REG_AW'(rd);
    ex_lat       = SEL_W'(lat);
    ex_rs        = {REG_AW'(rs1), REG_AW'(rs0)};
    flush        = fl;
    e.sel0 = s0; e.sel1 = s1; e.stl = st; e.cnt = cnt_model; e.id = vec_id;
    exp_q.push_back(e);
    vec_id++;
    if (!rst_n) cnt_model = 0;
    else if (st != 0 && !fl) cnt_model++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    ex_valid = 1'b0; ex_reg_write = 1'b0; ex_rd = '0; ex_lat = '0; ex_rs = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state: no entries, nothing matches.
    step(1, 0, 0, 1, 5, 5, 0, 0, 0, 0);
    rst_n = 1'b1;

    // Back-to-back ALU dependency.
    step(1, 1, 5, 1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 6, 1, 5, 0, 0, 1, 0, 0);
    step(1, 0, 0, 1, 0, 5, 0, 0, 2, 0);

    // Double hazard on x7 and rd/rs = x0.
    step(1, 1, 7, 1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 7, 1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 7, 0, 0, 1, 0, 0);
    step(1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 7, 0, 0, 3, 0);
    step(1, 0, 0, 1, 7, 0, 0, 4, 0, 0);

    // Load-use: one stall cycle, then stage-2 forward.
    step(1, 1, 3, 2, 0, 0, 0, 0, 0, 0);
    step(1, 1, 9, 1, 3, 0, 0, 1, 0, 1);
    step(1, 1, 9, 1, 3, 0, 0, 2, 0, 0);

    // Latency-4 producer directly ahead: three stalls, then stage-4 forward, then retired.
    step(1, 1, 4, 4, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 4, 0, 0, 1, 0, 1);
    step(1, 0, 0, 1, 4, 0, 0, 2, 0, 1);
    step(1, 0, 0, 1, 4, 0, 0, 3, 0, 1);
    step(1, 0, 0, 1, 4, 0, 0, 4, 0, 0);
    step(1, 0, 0, 1, 4, 0, 0, 0, 0, 0);

    // Depth boundary: 4 ahead matches, 5 ahead does not.
    step(1, 1, 8, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 8, 0, 0, 4, 0);
    step(1, 0, 0, 1, 0, 8, 0, 0, 0, 0);

    // Flush together with a load-use stall.
    step(1, 1, 3, 2, 0, 0, 0, 0, 0, 0);
    step(1, 1, 9, 1, 3, 0, 1, 1, 0, 1);
    step(1, 1, 9, 1, 3, 3, 0, 0, 0, 0);

    // Latency 0 clamps to 1: no stall.
    step(1, 1, 10, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 10, 0, 0, 1, 0, 0);

    // Latency 7 clamps to 4; an invalid consumer never stalls.
    step(1, 1, 11, 7, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 11, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0, 11, 0, 0, 2, 1);
    step(1, 0, 0, 1, 0, 11, 0, 0, 3, 1);
    step(1, 0, 0, 1, 0, 11, 0, 0, 4, 0);

    // Reset mid-operation with two valid entries.
    step(1, 1, 12, 1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 13, 1, 12, 0, 0, 1, 0, 0);
    rst_n = 1'b0;
    step(1, 0, 0, 1, 12, 13, 0, 2, 1, 0);
    rst_n = 1'b1;
    step(1, 0, 0, 1, 12, 13, 0, 0, 0, 0);

    repeat (2) @(posedge clk);
    done = 1'b1;
  end

  initial begin
    fork
      wait (done);
      begin
        repeat (2000) @(posedge clk);
        n_total++;
        $display("FAIL timeout: done=%0d, expected 1", done);
      end
    join_any
    disable fork;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
